// File: rtl/data_job_pkg.sv
// Shared types for the data_job_sequencer slice: job record, response codes, FSM states.
package data_job_pkg;

   localparam int AHB_ADDR_W = 32;
   localparam int PAYLOAD_W  = 128;

   typedef struct packed {
      logic                  write;
      logic [AHB_ADDR_W-1:0] addr;
      logic [PAYLOAD_W-1:0]  wdata;
   } job_t;

   typedef enum logic [1:0] {
      ERR_OK         = 2'b00,
      ERR_MISALIGNED = 2'b01,
      ERR_VERIFY     = 2'b10,
      ERR_NO_RDATA   = 2'b11
   } rsp_err_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_VERIFY,
      ST_RESP
   } seq_state_e;

endpackage

// File: rtl/data_job_sequencer_if.sv
// Client-facing job request / response port of data_job_sequencer.
interface data_job_sequencer_if;
   import data_job_pkg::*;

   logic                  I_req_valid;
   logic                  O_req_ready;
   logic                  I_req_write;
   logic [AHB_ADDR_W-1:0] I_req_addr;
   logic [PAYLOAD_W-1:0]  I_req_wdata;

   logic                  O_rsp_valid;
   logic                  I_rsp_ready;
   logic                  O_rsp_write;
   logic [AHB_ADDR_W-1:0] O_rsp_addr;
   logic [PAYLOAD_W-1:0]  O_rsp_rdata;
   logic [1:0]            O_rsp_err;

   modport slave (
      input  I_req_valid, I_req_write, I_req_addr, I_req_wdata, I_rsp_ready,
      output O_req_ready, O_rsp_valid, O_rsp_write, O_rsp_addr, O_rsp_rdata, O_rsp_err
   );

   modport master (
      output I_req_valid, I_req_write, I_req_addr, I_req_wdata, I_rsp_ready,
      input  O_req_ready, O_rsp_valid, O_rsp_write, O_rsp_addr, O_rsp_rdata, O_rsp_err
   );

endinterface

// File: rtl/data_job_fifo.sv
// Job FIFO with occupancy count; caller must not push when full or pop when empty.
module data_job_fifo
   import data_job_pkg::*;
#(
   parameter  int pDEPTH = 4,
   localparam int PTR_W  = $clog2(pDEPTH),
   localparam int CNT_W  = $clog2(pDEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             I_push,
   input  job_t             I_din,
   input  logic             I_pop,
   output job_t             O_dout,
   output logic             O_full,
   output logic             O_empty,
   output logic [CNT_W-1:0] O_count
);

   job_t             mem_q [pDEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (I_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (I_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (I_push && !I_pop)      count_d = count_q + CNT_W'(1);
      else if (!I_push && I_pop) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: a slot is only read after it has been written.
   always_ff @(posedge clk) begin
      if (I_push) mem_q[wr_ptr_q] <= I_din;
   end

   assign O_dout  = mem_q[rd_ptr_q];
   assign O_full  = (count_q == CNT_W'(pDEPTH));
   assign O_empty = (count_q == '0);
   assign O_count = count_q;

endmodule

// File: rtl/data_job_sequencer.sv
// Queues client jobs and issues them one at a time to data_worker over go/done.
// Optional write read-back check enabled by defining DATA_JOB_SEQ_VERIFY_EN.
module data_job_sequencer
   import data_job_pkg::*;
#(
   parameter  int pAHB_ADDR_WIDTH    = AHB_ADDR_W,
   parameter  int pPAYLOAD_SIZE_BITS = PAYLOAD_W,
   parameter  int pQUEUE_DEPTH       = 4,
   localparam int CNT_W              = $clog2(pQUEUE_DEPTH) + 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   data_job_sequencer_if.slave           req_if,
   output logic                          O_go,
   output logic                          O_int_write,
   output logic [pAHB_ADDR_WIDTH-1:0]    O_int_addr,
   output logic [pPAYLOAD_SIZE_BITS-1:0] O_int_wdata,
   input  logic                          I_done,
   input  logic [pPAYLOAD_SIZE_BITS-1:0] I_int_rdata,
   input  logic                          I_int_rdata_valid,
   output logic [CNT_W-1:0]              O_queue_count,
   output logic                          O_busy
);

   seq_state_e               state_q, state_d;
   job_t                     job_q, job_d;
   logic [PAYLOAD_W-1:0]     rdata_q, rdata_d;
   rsp_err_e                 err_q, err_d;

   logic fifo_push, fifo_pop, fifo_full, fifo_empty;
   job_t fifo_din, fifo_dout;

   assign fifo_push = req_if.I_req_valid && !fifo_full;
   assign fifo_din  = '{write: req_if.I_req_write, addr: req_if.I_req_addr, wdata: req_if.I_req_wdata};

   data_job_fifo #(.pDEPTH(pQUEUE_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .I_push  (fifo_push),
      .I_din   (fifo_din),
      .I_pop   (fifo_pop),
      .O_dout  (fifo_dout),
      .O_full  (fifo_full),
      .O_empty (fifo_empty),
      .O_count (O_queue_count)
   );

   always_comb begin
      state_d  = state_q;
      job_d    = job_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      fifo_pop = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               job_d    = fifo_dout;
               rdata_d  = '0;
               if (fifo_dout.addr[1:0] != 2'b00) begin
                  err_d   = ERR_MISALIGNED;
                  state_d = ST_RESP;
               end else begin
                  err_d   = ERR_OK;
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (I_done) begin
               state_d = ST_RESP;
               if (job_q.write) begin
                  rdata_d = '0;
                  err_d   = ERR_OK;
`ifdef DATA_JOB_SEQ_VERIFY_EN
                  state_d = ST_VERIFY;
`endif
               end else if (I_int_rdata_valid) begin
                  rdata_d = I_int_rdata;
                  err_d   = ERR_OK;
               end else begin
                  rdata_d = '0;
                  err_d   = ERR_NO_RDATA;
               end
            end
         end
         ST_VERIFY: begin
`ifdef DATA_JOB_SEQ_VERIFY_EN
            // A missing read-back counts as a verify failure.
            if (I_done) begin
               rdata_d = I_int_rdata_valid ? I_int_rdata : '0;
               err_d   = (!I_int_rdata_valid || (I_int_rdata != job_q.wdata)) ? ERR_VERIFY : ERR_OK;
               state_d = ST_RESP;
            end
`else
            state_d = ST_IDLE;
`endif
         end
         ST_RESP: begin
            if (req_if.I_rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         job_q   <= '0;
         rdata_q <= '0;
         err_q   <= ERR_OK;
      end else begin
         state_q <= state_d;
         job_q   <= job_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // The verify phase reuses the latched job but presents it as a read.
   assign O_go        = (state_q == ST_ISSUE) || (state_q == ST_VERIFY);
   assign O_int_write = job_q.write && (state_q != ST_VERIFY);
   assign O_int_addr  = job_q.addr;
   assign O_int_wdata = job_q.wdata;

   assign req_if.O_req_ready = !fifo_full;
   assign req_if.O_rsp_valid = (state_q == ST_RESP);
   assign req_if.O_rsp_write = job_q.write;
   assign req_if.O_rsp_addr  = job_q.addr;
   assign req_if.O_rsp_rdata = rdata_q;
   assign req_if.O_rsp_err   = err_q;

   assign O_busy = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_data_job_sequencer.sv
// Directed bench for data_job_sequencer with a small data_worker go/done model.
module tb_data_job_sequencer;
   import data_job_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         O_go, O_int_write, O_busy;
   logic [31:0]  O_int_addr;
   logic [127:0] O_int_wdata;
   logic         I_done = 1'b0;
   logic [127:0] I_int_rdata = '0;
   logic         I_int_rdata_valid = 1'b0;
   logic [2:0]   O_queue_count;

   data_job_sequencer_if rif ();

   data_job_sequencer dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .req_if            (rif),
      .O_go              (O_go),
      .O_int_write       (O_int_write),
      .O_int_addr        (O_int_addr),
      .O_int_wdata       (O_int_wdata),
      .I_done            (I_done),
      .I_int_rdata       (I_int_rdata),
      .I_int_rdata_valid (I_int_rdata_valid),
      .O_queue_count     (O_queue_count),
      .O_busy            (O_busy)
   );

   always #5 clk = ~clk;

   // Worker model: done after model_delay cycles of O_go, per go phase.
   int           model_delay     = 6;
   logic         model_valid     = 1'b1;
   logic         model_use_wdata = 1'b1;
   logic [127:0] model_xor       = '0;
   logic [127:0] model_rdata     = '0;
   int           go_cnt = 0, go_cycles = 0, go_phases = 0;

   always @(negedge clk) begin
      I_done            = 1'b0;
      I_int_rdata_valid = 1'b0;
      if (O_go) begin
         if (go_cnt == 0) go_phases++;
         go_cycles++;
         go_cnt++;
         if (go_cnt >= model_delay) begin
            I_done            = 1'b1;
            I_int_rdata_valid = model_valid;
            I_int_rdata       = model_use_wdata ? (O_int_wdata ^ model_xor) : model_rdata;
            go_cnt            = 0;
         end
      end else begin
         go_cnt = 0;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_job(input logic w, input logic [31:0] a, input logic [127:0] d);
      rif.I_req_valid = 1'b1;
      rif.I_req_write = w;
      rif.I_req_addr  = a;
      rif.I_req_wdata = d;
      @(negedge clk);
      rif.I_req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int start, output int ncyc);
      ncyc = start;
      while (!rif.O_rsp_valid && ncyc < 60) begin
         @(negedge clk);
         ncyc++;
      end
   endtask

   task automatic release_rsp();
      rif.I_rsp_ready = 1'b1;
      @(negedge clk);
      rif.I_rsp_ready = 1'b0;
   endtask

   localparam logic [127:0] WDATA1 = 128'h31c3001967d4acf1bcb25768708627ae;
   localparam logic [127:0] RDATA1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

   initial begin
      int           lat, g0, p0, n_acc, n_rsp, seen_rsp, seen_go;
      logic [31:0]  addrs [6];
      logic [31:0]  got_addr [5];

      rst_n = 1'b0;
      rif.I_req_valid = 1'b0;
      rif.I_req_write = 1'b0;
      rif.I_req_addr  = '0;
      rif.I_req_wdata = '0;
      rif.I_rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", rif.O_req_ready, 1);
      chk("rst_go", O_go, 0);
      chk("rst_rsp_valid", rif.O_rsp_valid, 0);
      chk("rst_count", O_queue_count, 0);
      chk("rst_busy", O_busy, 0);
      chk("rst_int_addr", O_int_addr, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Aligned write, 6-cycle worker
      g0 = go_cycles; p0 = go_phases;
      model_use_wdata = 1'b1; model_xor = '0; model_valid = 1'b1; model_delay = 6;
      push_job(1'b1, 32'h08, WDATA1);
      chk("wr_go_cycle1", O_go, 0);
      chk("wr_count_cycle1", O_queue_count, 1);
      @(negedge clk);
      chk("wr_go_cycle2", O_go, 1);
      chk("wr_int_write", O_int_write, 1);
      chk("wr_int_addr", O_int_addr, 32'h08);
      chk("wr_int_wdata", O_int_wdata, WDATA1);
      wait_rsp(2, lat);
`ifdef DATA_JOB_SEQ_VERIFY_EN
      chk("wr_rsp_latency", lat, 14);
      chk("wr_go_cycles", go_cycles - g0, 12);
      chk("wr_rsp_rdata", rif.O_rsp_rdata, WDATA1);
`else
      chk("wr_rsp_latency", lat, 8);
      chk("wr_go_cycles", go_cycles - g0, 6);
      chk("wr_rsp_rdata", rif.O_rsp_rdata, 0);
`endif
      chk("wr_go_low_in_resp", O_go, 0);
      chk("wr_rsp_write", rif.O_rsp_write, 1);
      chk("wr_rsp_addr", rif.O_rsp_addr, 32'h08);
      chk("wr_rsp_err", rif.O_rsp_err, 2'b00);
      @(negedge clk);
      chk("wr_rsp_held", rif.O_rsp_valid, 1);
      release_rsp();
      chk("wr_rsp_dropped", rif.O_rsp_valid, 0);
      chk("wr_idle_busy", O_busy, 0);

      // Aligned read with valid data
      g0 = go_cycles;
      model_use_wdata = 1'b0; model_rdata = RDATA1;
      push_job(1'b0, 32'h08, '0);
      chk("rd_go_cycle1", O_go, 0);
      @(negedge clk);
      chk("rd_go_cycle2", O_go, 1);
      chk("rd_int_write", O_int_write, 0);
      wait_rsp(2, lat);
      chk("rd_rsp_latency", lat, 8);
      chk("rd_go_cycles", go_cycles - g0, 6);
      chk("rd_rsp_write", rif.O_rsp_write, 0);
      chk("rd_rsp_rdata", rif.O_rsp_rdata, RDATA1);
      chk("rd_rsp_err", rif.O_rsp_err, 2'b00);
      release_rsp();

      // Read where the worker reports no data
      model_valid = 1'b0;
      push_job(1'b0, 32'h0C, '0);
      wait_rsp(1, lat);
      chk("nodata_rsp_latency", lat, 8);
      chk("nodata_rsp_err", rif.O_rsp_err, 2'b11);
      chk("nodata_rsp_rdata", rif.O_rsp_rdata, 0);
      release_rsp();
      model_valid = 1'b1;

      // Misaligned read: never issued
      g0 = go_cycles;
      push_job(1'b0, 32'h0A, '0);
      chk("mis_go_cycle1", O_go, 0);
      wait_rsp(1, lat);
      chk("mis_rsp_latency", lat, 2);
      chk("mis_rsp_err", rif.O_rsp_err, 2'b01);
      chk("mis_rsp_addr", rif.O_rsp_addr, 32'h0A);
      chk("mis_rsp_rdata", rif.O_rsp_rdata, 0);
      chk("mis_go_cycles", go_cycles - g0, 0);
      release_rsp();

      // Back-to-back pushes until the queue fills, responses held off
      addrs[0] = 32'h100; addrs[1] = 32'h104; addrs[2] = 32'h10A;
      addrs[3] = 32'h10C; addrs[4] = 32'h110; addrs[5] = 32'h114;
      model_delay = 40;
      n_acc = 0;
      for (int i = 0; i < 6; i++) begin
         rif.I_req_valid = 1'b1;
         rif.I_req_write = 1'b0;
         rif.I_req_addr  = addrs[i];
         rif.I_req_wdata = '0;
         if (rif.O_req_ready) n_acc++;
         @(negedge clk);
      end
      chk("full_req_ready", rif.O_req_ready, 0);
      chk("full_count", O_queue_count, 4);
      chk("full_accepted", n_acc, 5);
      rif.I_req_valid = 1'b0;
      @(negedge clk);
      chk("full_count_hold", O_queue_count, 4);
      model_delay = 2;
      rif.I_rsp_ready = 1'b1;
      n_rsp = 0;
      for (int t = 0; t < 300 && n_rsp < 5; t++) begin
         if (rif.O_rsp_valid) begin
            got_addr[n_rsp] = rif.O_rsp_addr;
            n_rsp++;
         end
         @(negedge clk);
      end
      rif.I_rsp_ready = 1'b0;
      chk("order_n_rsp", n_rsp, 5);
      for (int i = 0; i < 5; i++) begin
         if (i < n_rsp) chk($sformatf("order_addr%0d", i), got_addr[i], addrs[i]);
      end
      chk("order_count_empty", O_queue_count, 0);
      chk("order_busy", O_busy, 0);
      model_delay = 6;

      // Write with corrupted read-back
      g0 = go_cycles; p0 = go_phases;
      model_use_wdata = 1'b1; model_xor = 128'h1;
      push_job(1'b1, 32'h10, WDATA1);
      wait_rsp(1, lat);
`ifdef DATA_JOB_SEQ_VERIFY_EN
      chk("vfy_go_phases", go_phases - p0, 2);
      chk("vfy_rsp_err", rif.O_rsp_err, 2'b10);
      chk("vfy_rsp_rdata", rif.O_rsp_rdata, WDATA1 ^ 128'h1);
`else
      chk("vfy_go_phases", go_phases - p0, 1);
      chk("vfy_rsp_err", rif.O_rsp_err, 2'b00);
      chk("vfy_rsp_rdata", rif.O_rsp_rdata, 0);
`endif
      chk("vfy_rsp_write", rif.O_rsp_write, 1);
      release_rsp();
      model_xor = '0;

      // Reset while a job is in ISSUE with another queued
      model_delay = 10;
      model_use_wdata = 1'b0;
      push_job(1'b0, 32'h20, '0);
      push_job(1'b0, 32'h24, '0);
      chk("rstmid_go_before", O_go, 1);
      chk("rstmid_count_before", O_queue_count, 1);
      rst_n = 1'b0;
      #1;
      chk("rstmid_go", O_go, 0);
      chk("rstmid_count", O_queue_count, 0);
      chk("rstmid_rsp_valid", rif.O_rsp_valid, 0);
      chk("rstmid_req_ready", rif.O_req_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      seen_rsp = 0; seen_go = 0;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         if (rif.O_rsp_valid) seen_rsp++;
         if (O_go) seen_go++;
      end
      chk("rstmid_no_rsp", seen_rsp, 0);
      chk("rstmid_no_go", seen_go, 0);
      chk("rstmid_busy", O_busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
